// File: rtl/player_pkg.sv
// Shared types and constants for the player movement controller:
// FSM states, move kinds, button bit positions and fixed-point helper widths.
package player_pkg;

    localparam int NUM_BTNS     = 6;
    localparam int BTN_FWD      = 0;
    localparam int BTN_BWD      = 1;
    localparam int BTN_ROT_L    = 2;
    localparam int BTN_ROT_R    = 3;
    localparam int BTN_STRAFE_L = 4;
    localparam int BTN_STRAFE_R = 5;

    localparam int CELL_W = 8;
    // Internal precision of the heading table generator (Q2.30 in a longint).
    localparam int LUT_Q  = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WALL_REQ,
        ST_WALL_WAIT,
        ST_COMMIT,
        ST_ROT
    } state_t;

    typedef enum logic [1:0] {
        MV_FWD,
        MV_BWD,
        MV_STRAFE_L,
        MV_STRAFE_R
    } move_t;

endpackage

// File: rtl/heading_lut.sv
// Heading table: maps a heading index to (cos, sin) in signed fixed point, one cycle registered.
// The table is built at elaboration from ANGLE_STEPS with a first-quadrant Taylor series.
module heading_lut
    import player_pkg::*;
#(
    parameter int FP_W        = 16,
    parameter int FRAC_W      = 8,
    parameter int ANGLE_STEPS = 16
) (
    input  logic                        clk_in,
    input  logic [$clog2(ANGLE_STEPS)-1:0] idx,
    output logic signed [FP_W-1:0]      cos_out,
    output logic signed [FP_W-1:0]      sin_out
);

    localparam int     QTR         = ANGLE_STEPS / 4;
    localparam longint ONE_Q       = 64'sd1 <<< LUT_Q;
    localparam longint HALF_PI_Q   = 64'sd1686629713;

    function automatic longint taylor(input longint x, input bit odd);
        longint x2, term, acc;
        x2   = (x * x) >>> LUT_Q;
        term = odd ? x : ONE_Q;
        acc  = term;
        for (int k = 1; k <= 6; k++) begin
            term = -((term * x2) >>> LUT_Q) / (odd ? (2 * k) * (2 * k + 1) : (2 * k - 1) * (2 * k));
            acc  = acc + term;
        end
        return acc;
    endfunction

    function automatic logic signed [FP_W-1:0] to_fp(input longint v);
        longint r;
        r = (v + (64'sd1 <<< (LUT_Q - FRAC_W - 1))) >>> (LUT_Q - FRAC_W);
        return FP_W'(r);
    endfunction

    // Quadrant folding keeps the series argument within [0, pi/2).
    function automatic logic signed [FP_W-1:0] lut_val(input int i, input bit want_sin);
        int q, r;
        longint th;
        logic signed [FP_W-1:0] c, s, cv, sv;
        q  = i / QTR;
        r  = i % QTR;
        th = (HALF_PI_Q * r) / QTR;
        c  = to_fp(taylor(th, 1'b0));
        s  = to_fp(taylor(th, 1'b1));
        case (q)
            0:       begin cv = c;  sv = s;  end
            1:       begin cv = -s; sv = c;  end
            2:       begin cv = -c; sv = -s; end
            default: begin cv = s;  sv = -c; end
        endcase
        return want_sin ? sv : cv;
    endfunction

    logic signed [FP_W-1:0] cos_tab [ANGLE_STEPS];
    logic signed [FP_W-1:0] sin_tab [ANGLE_STEPS];

    for (genvar g = 0; g < ANGLE_STEPS; g++) begin : g_tab
        assign cos_tab[g] = lut_val(g, 1'b0);
        assign sin_tab[g] = lut_val(g, 1'b1);
    end

    always_ff @(posedge clk_in) begin
        cos_out <= cos_tab[idx];
        sin_out <= sin_tab[idx];
    end

endmodule

// File: rtl/player_control.sv
// Player movement controller: turns button levels into move/rotate events, checks moves
// against the wall map, and publishes a frame-stable copy of position and heading.
module player_control
    import player_pkg::*;
#(
    parameter int                     FP_W          = 16,
    parameter int                     FRAC_W        = 8,
    parameter int                     ANGLE_STEPS   = 16,
    parameter logic signed [FP_W-1:0] MOVE_STEP     = 16'h0040,
    parameter logic signed [FP_W-1:0] FOV_K         = 16'h00A9,
    parameter int                     REPEAT_CYCLES = 2_000_000,
    parameter logic signed [FP_W-1:0] START_X       = 16'h0180,
    parameter logic signed [FP_W-1:0] START_Y       = 16'h0180,
    parameter int                     MAP_CELLS     = 24
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_BTNS-1:0]     btn_in,
    input  logic                    frame_switch,
    output logic                    wall_req,
    output logic [CELL_W-1:0]       wall_cell_x,
    output logic [CELL_W-1:0]       wall_cell_y,
    input  logic                    wall_ack,
    input  logic                    wall_hit,
    output logic signed [FP_W-1:0]  posX,
    output logic signed [FP_W-1:0]  posY,
    output logic signed [FP_W-1:0]  dirX,
    output logic signed [FP_W-1:0]  dirY,
    output logic signed [FP_W-1:0]  planeX,
    output logic signed [FP_W-1:0]  planeY,
    output logic                    state_valid
);

    localparam int IDX_W = $clog2(ANGLE_STEPS);
    localparam int CNT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic signed [FP_W-1:0] ONE     = FP_W'(1 << FRAC_W);
    localparam logic signed [FP_W-1:0] POS_MIN = ONE;
    localparam logic signed [FP_W-1:0] POS_MAX = FP_W'(((MAP_CELLS - 1) << FRAC_W) - 1);

    function automatic logic signed [FP_W-1:0] fx_mul(input logic signed [FP_W-1:0] a,
                                                      input logic signed [FP_W-1:0] b);
        logic signed [2*FP_W-1:0] prod;
        prod = $signed({{FP_W{a[FP_W-1]}}, a}) * $signed({{FP_W{b[FP_W-1]}}, b});
        prod = prod >>> FRAC_W;
        return prod[FP_W-1:0];
    endfunction

    function automatic logic signed [FP_W-1:0] clamp_pos(input logic signed [FP_W-1:0] v);
        if (v < POS_MIN)      return POS_MIN;
        else if (v > POS_MAX) return POS_MAX;
        else                  return v;
    endfunction

    logic [NUM_BTNS-1:0]    btn_prev, btn_event;
    logic [CNT_W-1:0]       rep_cnt [NUM_BTNS];
    state_t                 state;
    move_t                  move, sel_move;
    logic                   take_move, take_rot, rot_left, hit_q;
    logic [IDX_W-1:0]       idx, idx_next;
    logic signed [FP_W-1:0] pos_x, pos_y, dir_x, dir_y, plane_x, plane_y;
    logic signed [FP_W-1:0] cand_x, cand_y, step_x, step_y, sum_x, sum_y;
    logic signed [FP_W-1:0] lut_cos, lut_sin;
    logic                   snap_d;

    heading_lut #(
        .FP_W        (FP_W),
        .FRAC_W      (FRAC_W),
        .ANGLE_STEPS (ANGLE_STEPS)
    ) u_lut (
        .clk_in  (clk_in),
        .idx     (idx_next),
        .cos_out (lut_cos),
        .sin_out (lut_sin)
    );

    // An event fires on the press itself and then every REPEAT_CYCLES samples while held.
    always_comb begin
        btn_event = '0;
        for (int i = 0; i < NUM_BTNS; i++)
            btn_event[i] = btn_in[i] && (!btn_prev[i] || rep_cnt[i] == REP_LAST);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            btn_prev <= '0;
            for (int i = 0; i < NUM_BTNS; i++) rep_cnt[i] <= '0;
        end else begin
            btn_prev <= btn_in;
            for (int i = 0; i < NUM_BTNS; i++)
                rep_cnt[i] <= (!btn_in[i] || btn_event[i]) ? '0 : rep_cnt[i] + CNT_W'(1);
        end
    end

    always_comb begin
        take_move = 1'b0;
        take_rot  = 1'b0;
        rot_left  = 1'b0;
        sel_move  = MV_FWD;
        if (btn_event[BTN_FWD])           take_move = 1'b1;
        else if (btn_event[BTN_BWD])      begin take_move = 1'b1; sel_move = MV_BWD;      end
        else if (btn_event[BTN_STRAFE_L]) begin take_move = 1'b1; sel_move = MV_STRAFE_L; end
        else if (btn_event[BTN_STRAFE_R]) begin take_move = 1'b1; sel_move = MV_STRAFE_R; end
        else if (btn_event[BTN_ROT_L])    begin take_rot  = 1'b1; rot_left = 1'b1;        end
        else if (btn_event[BTN_ROT_R])    take_rot = 1'b1;
    end

    // The table is addressed with the next index so its output lines up with ROT.
    always_comb begin
        idx_next = idx;
        if (rst_in)
            idx_next = '0;
        else if (state == ST_IDLE && !take_move && take_rot)
            idx_next = rot_left ? idx + IDX_W'(1) : idx - IDX_W'(1);
    end

    always_comb begin
        step_x = dir_x;
        step_y = dir_y;
        case (move)
            MV_FWD:      begin step_x = dir_x;  step_y = dir_y;  end
            MV_BWD:      begin step_x = -dir_x; step_y = -dir_y; end
            MV_STRAFE_L: begin step_x = -dir_y; step_y = dir_x;  end
            MV_STRAFE_R: begin step_x = dir_y;  step_y = -dir_x; end
        endcase
        sum_x = pos_x + fx_mul(step_x, MOVE_STEP);
        sum_y = pos_y + fx_mul(step_y, MOVE_STEP);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            move        <= MV_FWD;
            idx         <= '0;
            pos_x       <= START_X;
            pos_y       <= START_Y;
            dir_x       <= ONE;
            dir_y       <= '0;
            plane_x     <= '0;
            plane_y     <= FOV_K;
            cand_x      <= '0;
            cand_y      <= '0;
            hit_q       <= 1'b0;
            wall_req    <= 1'b0;
            wall_cell_x <= '0;
            wall_cell_y <= '0;
        end else begin
            idx <= idx_next;
            case (state)
                ST_IDLE: begin
                    if (take_move) begin
                        move  <= sel_move;
                        state <= ST_CALC;
                    end else if (take_rot) begin
                        state <= ST_ROT;
                    end
                end
                ST_CALC: begin
                    cand_x <= clamp_pos(sum_x);
                    cand_y <= clamp_pos(sum_y);
                    state  <= ST_WALL_REQ;
                end
                ST_WALL_REQ: begin
                    wall_req    <= 1'b1;
                    wall_cell_x <= CELL_W'(cand_x >> FRAC_W);
                    wall_cell_y <= CELL_W'(cand_y >> FRAC_W);
                    state       <= ST_WALL_WAIT;
                end
                ST_WALL_WAIT: begin
                    if (wall_ack) begin
                        hit_q    <= wall_hit;
                        wall_req <= 1'b0;
                        state    <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (!hit_q) begin
                        pos_x <= cand_x;
                        pos_y <= cand_y;
                    end
                    state <= ST_IDLE;
                end
                ST_ROT: begin
                    dir_x   <= lut_cos;
                    dir_y   <= lut_sin;
                    plane_x <= fx_mul(-lut_sin, FOV_K);
                    plane_y <= fx_mul(lut_cos, FOV_K);
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Non-blocking reads give the pre-commit state when a commit lands on the frame edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            posX        <= START_X;
            posY        <= START_Y;
            dirX        <= ONE;
            dirY        <= '0;
            planeX      <= '0;
            planeY      <= FOV_K;
            snap_d      <= 1'b0;
            state_valid <= 1'b0;
        end else begin
            snap_d      <= frame_switch;
            state_valid <= snap_d;
            if (frame_switch) begin
                posX   <= pos_x;
                posY   <= pos_y;
                dirX   <= dir_x;
                dirY   <= dir_y;
                planeX <= plane_x;
                planeY <= plane_y;
            end
        end
    end

endmodule

// File: tb/tb_player_control.sv
// Directed self-checking bench for player_control with a short auto-repeat period
// and a background wall-map responder.
module tb_player_control;

    localparam int REP = 20;

    localparam logic [5:0] B_FWD  = 6'b000001;
    localparam logic [5:0] B_BWD  = 6'b000010;
    localparam logic [5:0] B_ROTL = 6'b000100;
    localparam logic [5:0] B_ROTR = 6'b001000;
    localparam logic [5:0] B_STRL = 6'b010000;
    localparam logic [5:0] B_STRR = 6'b100000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [5:0]  btn_in = '0;
    logic        frame_switch = 1'b0;
    logic        wall_req, wall_ack, wall_hit, state_valid;
    logic [7:0]  wall_cell_x, wall_cell_y;
    logic [15:0] posX, posY, dirX, dirY, planeX, planeY;

    int          vectors = 0;
    int          miscompares = 0;

    bit          resp_en = 1'b1;
    bit          resp_hit = 1'b0;
    int          resp_delay = 0;
    int          req_seen = 0;
    int          wait_cnt = 0;
    logic [7:0]  seen_cx = '0, seen_cy = '0;

    always #5 clk_in = ~clk_in;

    player_control #(.REPEAT_CYCLES(REP)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .btn_in       (btn_in),
        .frame_switch (frame_switch),
        .wall_req     (wall_req),
        .wall_cell_x  (wall_cell_x),
        .wall_cell_y  (wall_cell_y),
        .wall_ack     (wall_ack),
        .wall_hit     (wall_hit),
        .posX         (posX),
        .posY         (posY),
        .dirX         (dirX),
        .dirY         (dirY),
        .planeX       (planeX),
        .planeY       (planeY),
        .state_valid  (state_valid)
    );

    // Wall map responder: acks a request after resp_delay cycles, pulsing ack for one cycle.
    initial begin
        wall_ack = 1'b0;
        wall_hit = 1'b0;
        forever begin
            @(negedge clk_in);
            if (wall_ack) begin
                wall_ack = 1'b0;
                wall_hit = 1'b0;
                wait_cnt = 0;
            end else if (wall_req && resp_en) begin
                if (wait_cnt >= resp_delay) begin
                    wall_ack = 1'b1;
                    wall_hit = resp_hit;
                    seen_cx  = wall_cell_x;
                    seen_cy  = wall_cell_y;
                    req_seen++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        btn_in = '0;
        frame_switch = 1'b0;
        resp_en = 1'b1;
        resp_hit = 1'b0;
        resp_delay = 0;
        tick(2);
        rst_in = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk_in);
        frame_switch = 1'b1;
        @(negedge clk_in);
        frame_switch = 1'b0;
    endtask

    task automatic press(input logic [5:0] mask);
        @(negedge clk_in);
        btn_in = mask;
        @(negedge clk_in);
        btn_in = '0;
        tick(14);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (posX !== 16'h0180) begin miscompares++; $display("[TB] FAIL reset_posX: got %h want 0180", posX); end
        vectors++; if (dirX !== 16'h0100) begin miscompares++; $display("[TB] FAIL reset_dirX: got %h want 0100", dirX); end
        vectors++; if (wall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wall_req: got %b want 0", wall_req); end
        vectors++; if (state_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_state_valid: got %b want 0", state_valid); end
        pulse_frame();
        vectors++; if (posX !== 16'h0180 || posY !== 16'h0180) begin miscompares++; $display("[TB] FAIL frame0_pos: got %h,%h want 0180,0180", posX, posY); end
        vectors++; if (dirX !== 16'h0100 || dirY !== 16'h0000) begin miscompares++; $display("[TB] FAIL frame0_dir: got %h,%h want 0100,0000", dirX, dirY); end
        vectors++; if (planeX !== 16'h0000 || planeY !== 16'h00A9) begin miscompares++; $display("[TB] FAIL frame0_plane: got %h,%h want 0000,00a9", planeX, planeY); end
        vectors++; if (state_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL valid_early: got %b want 0", state_valid); end
        @(negedge clk_in);
        vectors++; if (state_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL valid_pulse: got %b want 1", state_valid); end
        @(negedge clk_in);
        vectors++; if (state_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL valid_end: got %b want 0", state_valid); end
    endtask

    task automatic test_move_clear();
        int base;
        do_reset();
        resp_delay = 3;
        base = req_seen;
        @(negedge clk_in);
        btn_in = B_FWD;
        @(negedge clk_in);
        btn_in = '0;
        @(negedge clk_in);
        vectors++; if (wall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL req_too_early: got %b want 0", wall_req); end
        @(negedge clk_in);
        vectors++; if (wall_req !== 1'b1) begin miscompares++; $display("[TB] FAIL req_latency: got %b want 1", wall_req); end
        tick(14);
        pulse_frame();
        vectors++; if (posX !== 16'h01C0 || posY !== 16'h0180) begin miscompares++; $display("[TB] FAIL fwd_pos: got %h,%h want 01c0,0180", posX, posY); end
        vectors++; if (req_seen - base !== 1) begin miscompares++; $display("[TB] FAIL fwd_req_count: got %0d want 1", req_seen - base); end
        vectors++; if (wall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL req_released: got %b want 0", wall_req); end
    endtask

    task automatic test_wall_hit();
        do_reset();
        resp_hit = 1'b1;
        resp_delay = 1;
        press(B_FWD);
        pulse_frame();
        vectors++; if (posX !== 16'h0180 || posY !== 16'h0180) begin miscompares++; $display("[TB] FAIL hit_pos: got %h,%h want 0180,0180", posX, posY); end
        vectors++; if (seen_cx !== 8'd1 || seen_cy !== 8'd1) begin miscompares++; $display("[TB] FAIL hit_cell: got %0d,%0d want 1,1", seen_cx, seen_cy); end
    endtask

    task automatic test_directions();
        do_reset();
        press(B_BWD);
        pulse_frame();
        vectors++; if (posX !== 16'h0140) begin miscompares++; $display("[TB] FAIL bwd_posX: got %h want 0140", posX); end
        press(B_STRL);
        pulse_frame();
        vectors++; if (posY !== 16'h01C0 || posX !== 16'h0140) begin miscompares++; $display("[TB] FAIL strafeL_pos: got %h,%h want 0140,01c0", posX, posY); end
        press(B_STRR);
        pulse_frame();
        vectors++; if (posY !== 16'h0180) begin miscompares++; $display("[TB] FAIL strafeR_posY: got %h want 0180", posY); end
        press(B_BWD);
        pulse_frame();
        vectors++; if (posX !== 16'h0100) begin miscompares++; $display("[TB] FAIL bwd_to_min: got %h want 0100", posX); end
        press(B_BWD);
        pulse_frame();
        vectors++; if (posX !== 16'h0100) begin miscompares++; $display("[TB] FAIL sat_min_posX: got %h want 0100", posX); end
        vectors++; if (seen_cx !== 8'd1) begin miscompares++; $display("[TB] FAIL sat_cell_x: got %0d want 1", seen_cx); end
    endtask

    task automatic test_rotation();
        do_reset();
        press(B_ROTR);
        pulse_frame();
        vectors++; if (dirX < 16'h00EB || dirX > 16'h00ED) begin miscompares++; $display("[TB] FAIL rotR_dirX: got %h want 00ec+-1", dirX); end
        vectors++; if (dirY !== 16'hFF9E) begin miscompares++; $display("[TB] FAIL rotR_dirY: got %h want ff9e", dirY); end
        vectors++; if (planeX !== 16'h0040 || planeY !== 16'h009C) begin miscompares++; $display("[TB] FAIL rotR_plane: got %h,%h want 0040,009c", planeX, planeY); end
        press(B_ROTL);
        pulse_frame();
        vectors++; if (dirX !== 16'h0100 || dirY !== 16'h0000) begin miscompares++; $display("[TB] FAIL rotL_back_dir: got %h,%h want 0100,0000", dirX, dirY); end
        vectors++; if (planeX !== 16'h0000 || planeY !== 16'h00A9) begin miscompares++; $display("[TB] FAIL rotL_back_plane: got %h,%h want 0000,00a9", planeX, planeY); end
    endtask

    task automatic test_priority_repeat();
        int base;
        do_reset();
        base = req_seen;
        @(negedge clk_in);
        btn_in = B_FWD | B_ROTL;
        tick(3 * REP + 5);
        btn_in = '0;
        tick(14);
        pulse_frame();
        vectors++; if (req_seen - base !== 4) begin miscompares++; $display("[TB] FAIL repeat_count: got %0d want 4", req_seen - base); end
        vectors++; if (posX !== 16'h0280 || posY !== 16'h0180) begin miscompares++; $display("[TB] FAIL repeat_pos: got %h,%h want 0280,0180", posX, posY); end
        vectors++; if (dirX !== 16'h0100 || dirY !== 16'h0000) begin miscompares++; $display("[TB] FAIL prio_dir: got %h,%h want 0100,0000", dirX, dirY); end
    endtask

    task automatic test_frame_coincident();
        int n;
        do_reset();
        @(negedge clk_in);
        btn_in = B_FWD;
        @(negedge clk_in);
        btn_in = '0;
        n = 0;
        while (!wall_req && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        vectors++; if (wall_req !== 1'b1) begin miscompares++; $display("[TB] FAIL coinc_req_timeout: got %b want 1", wall_req); end
        @(negedge clk_in);
        frame_switch = 1'b1;
        @(negedge clk_in);
        frame_switch = 1'b0;
        vectors++; if (posX !== 16'h0180) begin miscompares++; $display("[TB] FAIL coinc_old_pos: got %h want 0180", posX); end
        tick(2);
        pulse_frame();
        vectors++; if (posX !== 16'h01C0) begin miscompares++; $display("[TB] FAIL coinc_next_pos: got %h want 01c0", posX); end
    endtask

    task automatic test_reset_mid_handshake();
        int n, base;
        do_reset();
        resp_en = 1'b0;
        base = req_seen;
        @(negedge clk_in);
        btn_in = B_FWD;
        @(negedge clk_in);
        btn_in = '0;
        n = 0;
        while (!wall_req && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        vectors++; if (wall_req !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_req_timeout: got %b want 1", wall_req); end
        rst_in = 1'b1;
        @(negedge clk_in);
        vectors++; if (wall_req !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_req_drop: got %b want 0", wall_req); end
        rst_in = 1'b0;
        resp_en = 1'b1;
        tick(6);
        pulse_frame();
        vectors++; if (posX !== 16'h0180 || req_seen !== base) begin miscompares++; $display("[TB] FAIL midrst_discard: got pos %h acks %0d want 0180 and %0d", posX, req_seen, base); end
    endtask

    initial begin
        $display("[TB] player_control directed bench start");
        test_reset();
        test_move_clear();
        test_wall_hit();
        test_directions();
        test_rotation();
        test_priority_repeat();
        test_frame_coincident();
        test_reset_mid_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
